jb_axi_slave_nep: RTL

- Parametrised AXI4-Lite slave that fans one AXI4-Lite port out to NUM_EP register-map endpoints.
- Endpoint is selected by the top address bits.
- Successor to the fixed two-endpoint slave. Adds:
  - independent AW/W acceptance
  - byte strobes
  - configurable endpoint read latency
  - DECERR for unmapped selects
- Sits between the interconnect and the generated regmap blocks.

---
 rtl/jb_axi_slave_nep.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/jb_axi_slave_nep.sv
// AXI4-Lite slave that fans one port out to NUM_EP register-map endpoints.
// The top address bits select the endpoint, and the remaining word bits form a shared offset.
// Write address and write data are held independently until both are present.
// Reads wait a fixed RD_LATENCY after the endpoint read strobe before capturing data.
// A select value at or above NUM_EP is unmapped and answers with DECERR.
module jb_axi_slave_nep #(
  parameter int AXI_ADDR_WIDTH = 13,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int NUM_EP         = 2,
  parameter int RD_LATENCY     = 1,
  localparam int EP_SEL_W      = $clog2(NUM_EP),
  localparam int ADDR_LSB      = $clog2(AXI_DATA_WIDTH / 8),
  localparam int OFS_W         = AXI_ADDR_WIDTH - EP_SEL_W - ADDR_LSB,
  localparam int STRB_W        = AXI_DATA_WIDTH / 8
) (
  input  logic                               clk,
  input  logic                               srst,
  input  logic [AXI_ADDR_WIDTH-1:0]          s_awaddr,
  input  logic                               s_awvalid,
  output logic                               s_awready,
  input  logic [AXI_DATA_WIDTH-1:0]          s_wdata,
  input  logic [STRB_W-1:0]                  s_wstrb,
  input  logic                               s_wvalid,
  output logic                               s_wready,
  output logic [1:0]                         s_bresp,
  output logic                               s_bvalid,
  input  logic                               s_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]          s_araddr,
  input  logic                               s_arvalid,
  output logic                               s_arready,
  output logic [AXI_DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                         s_rresp,
  output logic                               s_rvalid,
  input  logic                               s_rready,
  output logic [NUM_EP-1:0]                  ep_wren,
  output logic [OFS_W-1:0]                   ep_wr_offset,
  output logic [AXI_DATA_WIDTH-1:0]          ep_wdata,
  output logic [STRB_W-1:0]                  ep_wstrb,
  output logic [NUM_EP-1:0]                  ep_rden,
  output logic [OFS_W-1:0]                   ep_rd_offset,
  input  logic [NUM_EP*AXI_DATA_WIDTH-1:0]   ep_rdata
);

  localparam int         WA_W        = AXI_ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [2:0] RD_LAT_C    = 3'(RD_LATENCY);

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    RD_RESP  = 2'd3
  } rd_state_e;

  // A select is mapped when it names one of the instantiated endpoints.
  function automatic logic ep_mapped(input logic [EP_SEL_W-1:0] sel);
    return ({1'b0, sel} < (EP_SEL_W + 1)'(NUM_EP));
  endfunction

  // Expand a select into a one-hot endpoint vector.
  function automatic logic [NUM_EP-1:0] ep_onehot(input logic [EP_SEL_W-1:0] sel);
    logic [NUM_EP-1:0] oh;
    for (int k = 0; k < NUM_EP; k++) begin
      oh[k] = (sel == EP_SEL_W'(k));
    end
    return oh;
  endfunction

  // Byte-lane address bits carry no information for word-wide registers.
  logic addr_lsb_unused_s;
  assign addr_lsb_unused_s = ^{s_awaddr[ADDR_LSB-1:0], s_araddr[ADDR_LSB-1:0]};

  logic                      rdy_en_q;
  logic                      aw_full_q, aw_full_d;
  logic [WA_W-1:0]           awaddr_q, awaddr_d;
  logic                      w_full_q, w_full_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  rd_state_e                 rd_state_q, rd_state_d;
  logic [WA_W-1:0]           araddr_q, araddr_d;
  logic [2:0]                rd_cnt_q, rd_cnt_d;
  logic                      rvalid_q, rvalid_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                      aw_hs_s, w_hs_s, wr_issue_s, rd_issue_s;
  logic [EP_SEL_W-1:0]       wr_sel_s, rd_sel_s;
  logic [AXI_DATA_WIDTH-1:0] rd_word_s;

  // Readies stay low through reset and rise one cycle after it ends.
  assign s_awready  = rdy_en_q & ~aw_full_q;
  assign s_wready   = rdy_en_q & ~w_full_q;
  assign s_arready  = rdy_en_q & (rd_state_q == RD_IDLE);
  assign aw_hs_s    = s_awvalid & s_awready;
  assign w_hs_s     = s_wvalid & s_wready;
  assign wr_issue_s = aw_full_q & w_full_q & ~bvalid_q;
  assign wr_sel_s   = awaddr_q[WA_W-1 -: EP_SEL_W];
  assign rd_sel_s   = araddr_q[WA_W-1 -: EP_SEL_W];

  assign s_bvalid     = bvalid_q;
  assign s_bresp      = bresp_q;
  assign s_rvalid     = rvalid_q;
  assign s_rresp      = rresp_q;
  assign s_rdata      = rdata_q;
  assign ep_wr_offset = awaddr_q[OFS_W-1:0];
  assign ep_rd_offset = araddr_q[OFS_W-1:0];
  assign ep_wdata     = wdata_q;
  assign ep_wstrb     = wstrb_q;
  assign ep_wren      = (wr_issue_s & ep_mapped(wr_sel_s) & ~srst) ? ep_onehot(wr_sel_s) : '0;
  assign ep_rden      = (rd_issue_s & ~srst) ? ep_onehot(rd_sel_s) : '0;

  // Pick the read word of the selected endpoint.
  always_comb begin
    rd_word_s = '0;
    for (int k = 0; k < NUM_EP; k++) begin
      rd_word_s = rd_word_s | ({AXI_DATA_WIDTH{rd_sel_s == EP_SEL_W'(k)}} & ep_rdata[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]);
    end
  end

  // Write path: independent AW/W capture, issue when both are held and B is free.
  always_comb begin
    aw_full_d = aw_full_q;
    awaddr_d  = awaddr_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (wr_issue_s) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = ep_mapped(wr_sel_s) ? RESP_OKAY : RESP_DECERR;
    end else if (bvalid_q && s_bready) begin
      bvalid_d  = 1'b0;
    end else begin
      bvalid_d  = bvalid_q;
    end
    if (aw_hs_s) begin
      aw_full_d = 1'b1;
      awaddr_d  = s_awaddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
    end else begin
      awaddr_d  = awaddr_q;
    end
    if (w_hs_s) begin
      w_full_d  = 1'b1;
      wdata_d   = s_wdata;
      wstrb_d   = s_wstrb;
    end else begin
      wdata_d   = wdata_q;
    end
  end

  // Read FSM: accept address, strobe endpoint, wait out latency, hold response.
  always_comb begin
    rd_state_d = rd_state_q;
    araddr_d   = araddr_q;
    rd_cnt_d   = rd_cnt_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    rd_issue_s = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (s_arvalid && s_arready) begin
          araddr_d   = s_araddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
          rd_state_d = RD_ISSUE;
        end else begin
          rd_state_d = RD_IDLE;
        end
      end
      RD_ISSUE: begin
        if (!ep_mapped(rd_sel_s)) begin
          rdata_d    = '0;
          rresp_d    = RESP_DECERR;
          rvalid_d   = 1'b1;
          rd_state_d = RD_RESP;
        end else if (RD_LAT_C == 3'd0) begin
          rd_issue_s = 1'b1;
          rdata_d    = rd_word_s;
          rresp_d    = RESP_OKAY;
          rvalid_d   = 1'b1;
          rd_state_d = RD_RESP;
        end else begin
          rd_issue_s = 1'b1;
          rd_cnt_d   = RD_LAT_C;
          rd_state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rd_cnt_q <= 3'd1) begin
          rd_cnt_d   = 3'd0;
          rdata_d    = rd_word_s;
          rresp_d    = RESP_OKAY;
          rvalid_d   = 1'b1;
          rd_state_d = RD_RESP;
        end else begin
          rd_cnt_d   = rd_cnt_q - 3'd1;
        end
      end
      RD_RESP: begin
        if (s_rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_IDLE;
        end else begin
          rd_state_d = RD_RESP;
        end
      end
      default: begin
        rvalid_d   = 1'b0;
        rd_state_d = RD_IDLE;
      end
    endcase
  end

  // State registers; reset drops any in-flight transaction without a response.
  always_ff @(posedge clk) begin
    if (srst) begin
      rdy_en_q   <= 1'b0;
      aw_full_q  <= 1'b0;
      awaddr_q   <= '0;
      w_full_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rd_state_q <= RD_IDLE;
      araddr_q   <= '0;
      rd_cnt_q   <= 3'd0;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
    end else begin
      rdy_en_q   <= 1'b1;
      aw_full_q  <= aw_full_d;
      awaddr_q   <= awaddr_d;
      w_full_q   <= w_full_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      araddr_q   <= araddr_d;
      rd_cnt_q   <= rd_cnt_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule
